regfile_wb_arbiter: RTL and testbench

//  Shares the single regfile write port (we3/wa3/wd3) among NREQ writeback sources (ALU path,

---
 rtl/regfile_defs.sv | 9 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/regfile_defs.sv
// regfile_defs: shared register-file widths and the hard-wired zero register index.
package regfile_defs;
    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first valid requester at or after ptr, one-hot grant plus index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        // Scan from farthest to nearest so the closest valid requester overwrites the rest.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the regfile write port plus pending-write scoreboard.
// Define WB_ARB_R0_FILTER_EN to swallow accepted writes to r0 instead of driving them onto we3.
module regfile_wb_arbiter
    import regfile_defs::*;
#(
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*REG_AW-1:0]   req_addr,
    input  logic [NREQ*REG_DW-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     we3,
    output logic [REG_AW-1:0]        wa3,
    output logic [REG_DW-1:0]        wd3,
    input  logic                     sb_set,
    input  logic [REG_AW-1:0]        sb_set_addr,
    input  logic [REG_AW-1:0]        ra1,
    input  logic [REG_AW-1:0]        ra2,
    output logic                     busy1,
    output logic                     busy2
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]     grant;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       ptr_d, ptr_q;
    logic                we3_d, we3_q;
    reg_addr_t           wa3_d, wa3_q;
    reg_data_t           wd3_d, wd3_q;
    logic [NUM_REGS-1:0] sb_d, sb_q;
    logic                accept;
    reg_addr_t           gaddr;
    reg_data_t           gdata;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (idx)
    );

    always_comb begin
        req_ready = rst ? '0 : grant;
        accept    = |req_ready;
        gaddr     = req_addr[idx*REG_AW +: REG_AW];
        gdata     = req_data[idx*REG_DW +: REG_DW];
`ifdef WB_ARB_R0_FILTER_EN
        we3_d = accept && gaddr != REG_ZERO;
`else
        we3_d = accept;
`endif
        wa3_d = rst ? '0 : we3_d ? gaddr : wa3_q;
        wd3_d = rst ? '0 : we3_d ? gdata : wd3_q;
        ptr_d = rst ? '0 : !accept ? ptr_q : (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
        // Set is applied after clear so a newer producer of the same reg wins.
        sb_d  = rst ? '0 : (sb_q & ~(accept ? NUM_REGS'(1) << gaddr : '0))
                           | ((sb_set && sb_set_addr != REG_ZERO) ? NUM_REGS'(1) << sb_set_addr : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
            ptr_q <= '0;
            sb_q  <= '0;
        end else begin
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
            ptr_q <= ptr_d;
            sb_q  <= sb_d;
        end
    end

    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    // The write on we3/wa3 lands this edge, so readers see it through the regfile bypass.
    assign busy1 = sb_q[ra1] & ~(we3_q && wa3_q == ra1);
    assign busy2 = sb_q[ra2] & ~(we3_q && wa3_q == ra2);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant order, output latency, scoreboard and r0 handling.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        sb_set;
    logic [4:0]  sb_set_addr, ra1, ra2;
    logic        busy1, busy2;
    int          n_chk = 0;
    int          n_fail = 0;

    regfile_wb_arbiter #(.NREQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .we3         (we3),
        .wa3         (wa3),
        .wd3         (wd3),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_addr = {5'd2, 5'd1}; req_data = {32'h22, 32'h11};
        sb_set = 1'b0; sb_set_addr = '0; ra1 = 5'd1; ra2 = 5'd2;
        settle(); check("rst_ready", 32'(req_ready), 0);
        tick(); check("rst_ready2", 32'(req_ready), 0);
        tick();
        check("rst_we3", 32'(we3), 0); check("rst_wa3", 32'(wa3), 0); check("rst_wd3", wd3, 0);
        check("rst_busy1", 32'(busy1), 0); check("rst_busy2", 32'(busy2), 0);
        rst = 1'b0; req_valid = 2'b00;
        tick();
        // single request from requester 1
        req_valid = 2'b10; req_addr = {5'd5, 5'd0}; req_data = {32'hDEADBEEF, 32'h0};
        settle(); check("single_ready", 32'(req_ready), 32'b10);
        tick(); req_valid = 2'b00;
        check("single_we3", 32'(we3), 1); check("single_wa3", 32'(wa3), 5); check("single_wd3", wd3, 32'hDEADBEEF);
        tick();
        check("idle_we3", 32'(we3), 0); check("idle_wa3_hold", 32'(wa3), 5); check("idle_wd3_hold", wd3, 32'hDEADBEEF);
        // contention: grants must alternate 0,1,0,1
        req_addr = {5'd11, 5'd10}; req_data = {32'hA1, 32'hA0};
        req_valid = 2'b11; settle(); check("cont_g0", 32'(req_ready), 32'b01);
        tick(); req_valid = 2'b10; settle(); check("cont_g1", 32'(req_ready), 32'b10);
        check("cont_w0", 32'(we3), 1); check("cont_a0", 32'(wa3), 10);
        tick(); req_valid = 2'b01; settle(); check("cont_g2", 32'(req_ready), 32'b01);
        check("cont_w1", 32'(we3), 1); check("cont_a1", 32'(wa3), 11);
        tick(); req_valid = 2'b10; settle(); check("cont_g3", 32'(req_ready), 32'b10);
        check("cont_w2", 32'(we3), 1); check("cont_a2", 32'(wa3), 10);
        tick(); req_valid = 2'b00;
        check("cont_w3", 32'(we3), 1); check("cont_a3", 32'(wa3), 11); check("cont_d3", wd3, 32'hA1);
        tick(); check("cont_end", 32'(we3), 0);
        // scoreboard set, hold, clear
        ra1 = 5'd7; sb_set = 1'b1; sb_set_addr = 5'd7;
        settle(); check("sb_pre", 32'(busy1), 0);
        tick(); sb_set = 1'b0; check("sb_set", 32'(busy1), 1);
        tick(); check("sb_hold", 32'(busy1), 1);
        req_valid = 2'b01; req_addr = {5'd0, 5'd7}; req_data = {32'h0, 32'h77};
        settle(); check("sb_wr_ready", 32'(req_ready), 32'b01);
        tick(); req_valid = 2'b00; check("sb_clr", 32'(busy1), 0);
        tick(); check("sb_clr_stay", 32'(busy1), 0);
        ra1 = 5'd0; sb_set = 1'b1; sb_set_addr = 5'd0;
        tick(); sb_set = 1'b0; check("sb_r0", 32'(busy1), 0);
        tick(); check("sb_r0_2", 32'(busy1), 0);
        // set and clear of reg 9 in the same cycle: set wins
        ra2 = 5'd9; req_valid = 2'b01; req_addr = {5'd0, 5'd9}; req_data = {32'h0, 32'h99};
        sb_set = 1'b1; sb_set_addr = 5'd9;
        tick(); req_valid = 2'b00; sb_set = 1'b0;
        check("coll_we3", 32'(we3), 1); check("coll_wa3", 32'(wa3), 9); check("coll_bypass", 32'(busy2), 0);
        tick(); check("coll_busy", 32'(busy2), 1);
        // pointer now 1: with both valid requester 1 wins
        req_valid = 2'b11; req_addr = {5'd12, 5'd13}; req_data = {32'hC, 32'hD};
        settle(); check("ptr1_grant", 32'(req_ready), 32'b10);
        tick(); req_valid = 2'b01; settle(); check("ptr1_next", 32'(req_ready), 32'b01);
        check("ptr1_wa3", 32'(wa3), 12);
        tick(); req_valid = 2'b00; check("ptr1_wa3b", 32'(wa3), 13); check("ptr1_wd3b", wd3, 32'hD);
        // write to r0
        req_valid = 2'b01; req_addr = {5'd0, 5'd0}; req_data = {32'h0, 32'h1};
        settle(); check("r0_ready", 32'(req_ready), 32'b01);
        tick(); req_valid = 2'b00;
`ifdef WB_ARB_R0_FILTER_EN
        check("r0_filtered", 32'(we3), 0);
`else
        check("r0_we3", 32'(we3), 1); check("r0_wa3", 32'(wa3), 0); check("r0_wd3", wd3, 1);
`endif
        // reset right after an accept drops the in-flight write and clears the scoreboard
        req_valid = 2'b10; req_addr = {5'd3, 5'd0}; req_data = {32'h33, 32'h0};
        tick(); req_valid = 2'b11; rst = 1'b1;
        check("rstmid_we3_pre", 32'(we3), 1); check("rstmid_wa3_pre", 32'(wa3), 3);
        settle(); check("rstmid_ready", 32'(req_ready), 0);
        tick(); rst = 1'b0; req_valid = 2'b00;
        check("rstmid_we3", 32'(we3), 0); check("rstmid_wa3", 32'(wa3), 0); check("rstmid_busy2", 32'(busy2), 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
